// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Converts Z80 I/O-port writes into VRAM byte writes and shares the single
//   SDRAM port between those writes, a hardware fill and display reads.
//   Arbitration happens once per SDRAM slot. Display reads win, but a pending
//   write or fill gets a guaranteed share.
// Ports
//   clk, reset                 clk64 clock, asynchronous active-high reset
//   io_wr_stb/io_addr/io_data  synchronised Z80 port write (one-cycle strobe)
//   slot                       one-cycle pulse at the start of an SDRAM slot
//   disp_req/disp_addr         display read request and word address
//   sdram_addr/we/din/mask     registered command for the current slot
//   disp_grant                 current slot serves the display
//   fifo_full/overflow         write FIFO status, overflow is sticky
//   fill_busy                  hardware fill in progress
module vram_write_scheduler #(
    parameter logic [7:0]  IO_BASE     = 8'h40,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WRITE_EVERY = 4,
    parameter logic [15:0] FILL_WORDS  = 16'h0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr_stb,
    input  logic [7:0]  io_addr,
    input  logic [7:0]  io_data,
    input  logic        slot,
    input  logic        disp_req,
    input  logic [15:0] disp_addr,
    output logic [15:0] sdram_addr,
    output logic        sdram_we,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_mask,
    output logic        disp_grant,
    output logic        fifo_full,
    output logic        overflow,
    output logic        fill_busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(WRITE_EVERY + 1);

    localparam logic [7:0] PORT_LO   = IO_BASE;
    localparam logic [7:0] PORT_HI   = IO_BASE + 8'd1;
    localparam logic [7:0] PORT_DATA = IO_BASE + 8'd2;
    localparam logic [7:0] PORT_CMD  = IO_BASE + 8'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_DISP, ST_WRITE, ST_FILL} slot_kind_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

    slot_kind_e       state_q, state_d;
    logic [15:0]      vaddr_q, vaddr_d;
    wr_entry_t        mem_q [FIFO_DEPTH];
    wr_entry_t        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full_q, fifo_full_d;
    logic             overflow_q, overflow_d;
    logic             fill_busy_q, fill_busy_d;
    logic [15:0]      fill_ptr_q, fill_ptr_d;
    logic [7:0]       fill_val_q, fill_val_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [15:0]      sdram_addr_q, sdram_addr_d;
    logic             sdram_we_q, sdram_we_d;
    logic [15:0]      sdram_din_q, sdram_din_d;
    logic [1:0]       sdram_mask_q, sdram_mask_d;

    logic      push, pop, pending;
    wr_entry_t head;

    assign head = mem_q[rd_ptr_q];

    // Slot arbitration (pre-push FIFO state) and I/O port decode
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        fill_busy_d  = fill_busy_q;
        fill_ptr_d   = fill_ptr_q;
        fill_val_d   = fill_val_q;
        starve_d     = starve_q;
        sdram_addr_d = sdram_addr_q;
        sdram_we_d   = sdram_we_q;
        sdram_din_d  = sdram_din_q;
        sdram_mask_d = sdram_mask_q;
        push         = 1'b0;
        pop          = 1'b0;
        pending      = fill_busy_q | (count_q != '0);

        if (slot) begin
            if (disp_req && (!pending || (starve_q < STV_W'(WRITE_EVERY)))) begin
                state_d      = ST_DISP;
                sdram_addr_d = disp_addr;
                sdram_we_d   = 1'b0;
                sdram_mask_d = 2'b00;
                starve_d     = pending ? (starve_q + STV_W'(1)) : '0;
            end else if (fill_busy_q) begin
                state_d      = ST_FILL;
                sdram_addr_d = fill_ptr_q;
                sdram_we_d   = 1'b1;
                sdram_din_d  = {fill_val_q, fill_val_q};
                sdram_mask_d = 2'b00;
                fill_ptr_d   = fill_ptr_q + 16'd1;
                starve_d     = '0;
                if (fill_ptr_q == (FILL_WORDS - 16'd1)) begin
                    fill_busy_d = 1'b0;
                end
            end else if (count_q != '0) begin
                state_d      = ST_WRITE;
                pop          = 1'b1;
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                sdram_addr_d = {1'b0, head.addr[15:1]};
                sdram_we_d   = 1'b1;
                sdram_din_d  = {head.data, head.data};
                // Odd byte lives in the upper lane, so mask the lower one
                sdram_mask_d = head.addr[0] ? 2'b01 : 2'b10;
                starve_d     = '0;
            end else begin
                state_d      = ST_IDLE;
                sdram_we_d   = 1'b0;
                sdram_mask_d = 2'b11;
                starve_d     = '0;
            end
        end

        if (io_wr_stb) begin
            if (io_addr == PORT_LO) begin
                vaddr_d[7:0] = io_data;
            end else if (io_addr == PORT_HI) begin
                vaddr_d[15:8] = io_data;
            end else if (io_addr == PORT_DATA) begin
                // A same-cycle pop frees the slot even when full
                if ((count_q != CNT_W'(FIFO_DEPTH)) || pop) begin
                    push            = 1'b1;
                    mem_d[wr_ptr_q] = '{addr: vaddr_q, data: io_data};
                    wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                vaddr_d = vaddr_q + 16'd1;
            end else if (io_addr == PORT_CMD) begin
                overflow_d = 1'b0;
                if (io_data[0] && !fill_busy_q) begin
                    fill_busy_d = 1'b1;
                    fill_ptr_d  = '0;
                    fill_val_d  = io_data;
                end
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        fifo_full_d = (count_d == CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vaddr_q      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fifo_full_q  <= 1'b0;
            overflow_q   <= 1'b0;
            fill_busy_q  <= 1'b0;
            fill_ptr_q   <= '0;
            fill_val_q   <= '0;
            starve_q     <= '0;
            sdram_addr_q <= '0;
            sdram_we_q   <= 1'b0;
            sdram_din_q  <= '0;
            sdram_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            vaddr_q      <= vaddr_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_full_q  <= fifo_full_d;
            overflow_q   <= overflow_d;
            fill_busy_q  <= fill_busy_d;
            fill_ptr_q   <= fill_ptr_d;
            fill_val_q   <= fill_val_d;
            starve_q     <= starve_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_we_q   <= sdram_we_d;
            sdram_din_q  <= sdram_din_d;
            sdram_mask_q <= sdram_mask_d;
        end
    end

    assign sdram_addr = sdram_addr_q;
    assign sdram_we   = sdram_we_q;
    assign sdram_din  = sdram_din_q;
    assign sdram_mask = sdram_mask_q;
    assign disp_grant = (state_q == ST_DISP);
    assign fifo_full  = fifo_full_q;
    assign overflow   = overflow_q;
    assign fill_busy  = fill_busy_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler
//   Directed scenarios checked against hand-derived constants, then a random
//   phase checked every cycle against a queue-based reference model.
module tb_vram_write_scheduler;

    localparam int FIFO_DEPTH  = 4;
    localparam int WRITE_EVERY = 4;
    localparam int FILL_WORDS  = 'h800;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_wr_stb;
    logic [7:0]  io_addr;
    logic [7:0]  io_data;
    logic        slot;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic [15:0] sdram_addr;
    logic        sdram_we;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_mask;
    logic        disp_grant;
    logic        fifo_full;
    logic        overflow;
    logic        fill_busy;

    int checks   = 0;
    int failures = 0;

    vram_write_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .io_wr_stb  (io_wr_stb),
        .io_addr    (io_addr),
        .io_data    (io_data),
        .slot       (slot),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .sdram_addr (sdram_addr),
        .sdram_we   (sdram_we),
        .sdram_din  (sdram_din),
        .sdram_mask (sdram_mask),
        .disp_grant (disp_grant),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .fill_busy  (fill_busy)
    );

    always #5 clk = ~clk;

    // Reference model: byte-write queue plus fill and starvation bookkeeping
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_vaddr;
    bit          m_ovf, m_busy;
    int          m_ptr, m_starve;
    logic [7:0]  m_fv;
    logic [15:0] e_addr, e_din;
    logic        e_we, e_grant;
    logic [1:0]  e_mask;

    function automatic void model_reset();
        m_q.delete();
        m_vaddr = 16'h0; m_ovf = 0; m_busy = 0; m_ptr = 0; m_starve = 0; m_fv = 8'h0;
        e_addr = 16'h0; e_din = 16'h0; e_we = 0; e_grant = 0; e_mask = 2'b00;
    endfunction

    function automatic void model_edge();
        bit   pend, busy0;
        ent_t h;
        busy0 = m_busy;
        if (slot) begin
            pend = m_busy || (m_q.size() != 0);
            if (disp_req && (!pend || m_starve < WRITE_EVERY)) begin
                e_addr = disp_addr; e_we = 0; e_mask = 2'b00; e_grant = 1;
                m_starve = pend ? m_starve + 1 : 0;
            end else if (m_busy) begin
                e_addr = 16'(m_ptr); e_we = 1; e_din = {m_fv, m_fv}; e_mask = 2'b00; e_grant = 0;
                m_ptr = m_ptr + 1;
                if (m_ptr == FILL_WORDS) m_busy = 0;
                m_starve = 0;
            end else if (m_q.size() != 0) begin
                h = m_q.pop_front();
                e_addr = h.a / 16'd2; e_we = 1; e_din = {h.d, h.d}; e_grant = 0;
                e_mask = (h.a % 16'd2 == 16'd1) ? 2'b01 : 2'b10;
                m_starve = 0;
            end else begin
                e_we = 0; e_mask = 2'b11; e_grant = 0; m_starve = 0;
            end
        end
        if (io_wr_stb) begin
            case (io_addr)
                8'h40: m_vaddr[7:0]  = io_data;
                8'h41: m_vaddr[15:8] = io_data;
                8'h42: begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back({m_vaddr, io_data});
                    else m_ovf = 1;
                    m_vaddr = m_vaddr + 16'd1;
                end
                8'h43: begin
                    m_ovf = 0;
                    if (io_data[0] && !busy0) begin
                        m_busy = 1; m_ptr = 0; m_fv = io_data;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // One clock: drive at negedge, model updates on posedge, return at next negedge
    task automatic step(input logic stb, input logic [7:0] a, input logic [7:0] d,
                        input logic sl, input logic dr, input logic [15:0] da);
        io_wr_stb = stb; io_addr = a; io_data = d;
        slot = sl; disp_req = dr; disp_addr = da;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        io_wr_stb = 1'b0;
        slot      = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_slot(input logic dr, input logic [15:0] da);
        step(1'b0, 8'h00, 8'h00, 1'b1, dr, da);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io_wr_stb = 1'b0; io_addr = 8'h0; io_data = 8'h0;
        slot = 1'b0; disp_req = 1'b0; disp_addr = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sdram_addr, sdram_we, sdram_din, sdram_mask, disp_grant, fifo_full, overflow, fill_busy} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h we=%b din=%h mask=%b grant=%b full=%b ovf=%b busy=%b, expected all 0",
                     sdram_addr, sdram_we, sdram_din, sdram_mask, disp_grant, fifo_full, overflow, fill_busy);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        io_write(8'h40, 8'h34);
        io_write(8'h41, 8'h12);
        io_write(8'h42, 8'hAB);
        io_write(8'h42, 8'hCD);
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_we, sdram_mask, sdram_din} !== {16'h091A, 1'b1, 2'b10, 16'hABAB}) begin
            failures++;
            $display("FAIL basic_even: got addr=%h we=%b mask=%b din=%h, expected 091a 1 10 abab",
                     sdram_addr, sdram_we, sdram_mask, sdram_din);
        end
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_we, sdram_mask, sdram_din} !== {16'h091A, 1'b1, 2'b01, 16'hCDCD}) begin
            failures++;
            $display("FAIL basic_odd: got addr=%h we=%b mask=%b din=%h, expected 091a 1 01 cdcd",
                     sdram_addr, sdram_we, sdram_mask, sdram_din);
        end
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_we, sdram_mask, disp_grant} !== {16'h091A, 1'b0, 2'b11, 1'b0}) begin
            failures++;
            $display("FAIL basic_idle: got addr=%h we=%b mask=%b grant=%b, expected 091a 0 11 0",
                     sdram_addr, sdram_we, sdram_mask, disp_grant);
        end
    endtask

    task automatic test_write_share();
        do_reset();
        io_write(8'h40, 8'h01);
        io_write(8'h41, 8'h01);
        io_write(8'h42, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            do_slot(1'b1, 16'h4000 + 16'(i));
            checks++;
            if ({disp_grant, sdram_we, sdram_addr, sdram_mask} !== {1'b1, 1'b0, 16'h4000 + 16'(i), 2'b00}) begin
                failures++;
                $display("FAIL share_disp%0d: got grant=%b we=%b addr=%h mask=%b, expected 1 0 %h 00",
                         i, disp_grant, sdram_we, sdram_addr, sdram_mask, 16'h4000 + 16'(i));
            end
        end
        do_slot(1'b1, 16'h4004);
        checks++;
        if ({disp_grant, sdram_we, sdram_addr, sdram_mask, sdram_din} !== {1'b0, 1'b1, 16'h0080, 2'b01, 16'h3C3C}) begin
            failures++;
            $display("FAIL share_write: got grant=%b we=%b addr=%h mask=%b din=%h, expected 0 1 0080 01 3c3c",
                     disp_grant, sdram_we, sdram_addr, sdram_mask, sdram_din);
        end
        do_slot(1'b1, 16'h4005);
        checks++;
        if ({disp_grant, sdram_we, sdram_addr} !== {1'b1, 1'b0, 16'h4005}) begin
            failures++;
            $display("FAIL share_resume: got grant=%b we=%b addr=%h, expected 1 0 4005",
                     disp_grant, sdram_we, sdram_addr);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        io_write(8'h40, 8'h00);
        io_write(8'h41, 8'h20);
        for (int k = 1; k <= 6; k++) begin
            io_write(8'h42, 8'(k));
            checks++;
            if ({fifo_full, overflow} !== {1'(k >= 4), 1'(k >= 5)}) begin
                failures++;
                $display("FAIL ovf_push%0d: got full=%b ovf=%b, expected %b %b",
                         k, fifo_full, overflow, k >= 4, k >= 5);
            end
        end
        io_write(8'h43, 8'h00);
        checks++;
        if ({overflow, fill_busy, fifo_full} !== 3'b001) begin
            failures++;
            $display("FAIL ovf_clear: got ovf=%b busy=%b full=%b, expected 0 0 1", overflow, fill_busy, fifo_full);
        end
        for (int k = 1; k <= 4; k++) begin
            do_slot(1'b0, 16'h0);
            checks++;
            if ({sdram_addr, sdram_mask, sdram_din, fifo_full} !==
                {16'h1000 + 16'((k - 1) / 2), ((k % 2) == 1) ? 2'b10 : 2'b01, {8'(k), 8'(k)}, 1'b0}) begin
                failures++;
                $display("FAIL ovf_drain%0d: got addr=%h mask=%b din=%h full=%b", k, sdram_addr, sdram_mask, sdram_din, fifo_full);
            end
        end
        // Dropped writes still advanced vaddr: next byte lands at 0x2006
        io_write(8'h42, 8'hEE);
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_mask, sdram_din} !== {16'h1003, 2'b10, 16'hEEEE}) begin
            failures++;
            $display("FAIL ovf_vaddr: got addr=%h mask=%b din=%h, expected 1003 10 eeee", sdram_addr, sdram_mask, sdram_din);
        end
    endtask

    task automatic test_fill();
        int bad;
        bad = 0;
        do_reset();
        io_write(8'h40, 8'h10);
        io_write(8'h41, 8'h00);
        io_write(8'h42, 8'h99);
        io_write(8'h43, 8'h5B);
        checks++;
        if (fill_busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_start: got busy=%b, expected 1", fill_busy);
        end
        for (int i = 0; i < FILL_WORDS; i++) begin
            do_slot(1'b0, 16'h0);
            if ({sdram_addr, sdram_we, sdram_din, sdram_mask, disp_grant} !== {16'(i), 1'b1, 16'h5B5B, 2'b00, 1'b0})
                bad++;
            if (i == FILL_WORDS - 2) begin
                checks++;
                if (fill_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL fill_busy_before_last: got %b, expected 1", fill_busy);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill_words: got %0d bad fill slots, expected 0", bad);
        end
        checks++;
        if (fill_busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_done: got busy=%b, expected 0", fill_busy);
        end
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_we, sdram_mask, sdram_din} !== {16'h0008, 1'b1, 2'b10, 16'h9999}) begin
            failures++;
            $display("FAIL fill_then_fifo: got addr=%h we=%b mask=%b din=%h, expected 0008 1 10 9999",
                     sdram_addr, sdram_we, sdram_mask, sdram_din);
        end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        io_write(8'h42, 8'h77);
        io_write(8'h43, 8'h5B);
        for (int i = 0; i < 'h100; i++) do_slot(1'b0, 16'h0);
        checks++;
        if ({fill_busy, sdram_addr} !== {1'b1, 16'h00FF}) begin
            failures++;
            $display("FAIL midfill_pre: got busy=%b addr=%h, expected 1 00ff", fill_busy, sdram_addr);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sdram_addr, sdram_we, sdram_din, sdram_mask, disp_grant, fifo_full, overflow, fill_busy} !== 39'd0) begin
            failures++;
            $display("FAIL midfill_async: got addr=%h we=%b din=%h mask=%b busy=%b, expected all 0",
                     sdram_addr, sdram_we, sdram_din, sdram_mask, fill_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_we, sdram_mask, disp_grant, fill_busy, fifo_full, sdram_addr} !== {1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL midfill_after: got we=%b mask=%b grant=%b busy=%b full=%b addr=%h, expected idle",
                     sdram_we, sdram_mask, disp_grant, fill_busy, fifo_full, sdram_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        io_write(8'h40, 8'hFF);
        io_write(8'h41, 8'hFF);
        io_write(8'h42, 8'h11);
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_mask, sdram_din} !== {16'h7FFF, 2'b01, 16'h1111}) begin
            failures++;
            $display("FAIL wrap_top: got addr=%h mask=%b din=%h, expected 7fff 01 1111", sdram_addr, sdram_mask, sdram_din);
        end
        io_write(8'h42, 8'h22);
        do_slot(1'b0, 16'h0);
        checks++;
        if ({sdram_addr, sdram_mask, sdram_din} !== {16'h0000, 2'b10, 16'h2222}) begin
            failures++;
            $display("FAIL wrap_zero: got addr=%h mask=%b din=%h, expected 0000 10 2222", sdram_addr, sdram_mask, sdram_din);
        end
    endtask

    task automatic test_random();
        logic [7:0]  tab [8];
        logic        stb, sl, dr;
        logic [7:0]  a, d;
        logic [15:0] da;
        logic [22:0] act, exp_v;
        tab = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h42, 8'h43, 8'h44, 8'h3F};
        do_reset();
        for (int i = 0; i < 800; i++) begin
            stb = ($urandom_range(0, 2) == 0);
            a   = tab[$urandom_range(0, 7)];
            d   = 8'($urandom);
            if (a == 8'h43 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
            sl  = (i < 400) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            dr  = ($urandom_range(0, 1) == 0);
            da  = 16'($urandom);
            step(stb, a, d, sl, dr, da);
            act   = {sdram_addr, sdram_we, sdram_mask, disp_grant, fifo_full, overflow, fill_busy};
            exp_v = {e_addr, e_we, e_mask, e_grant, 1'(m_q.size() == FIFO_DEPTH), m_ovf, m_busy};
            checks++;
            if ((act !== exp_v) || (e_we && (sdram_din !== e_din))) begin
                failures++;
                $display("FAIL random_cycle%0d: got {addr,we,mask,grant,full,ovf,busy}=%h din=%h, expected %h din=%h",
                         i, act, sdram_din, exp_v, e_din);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_write_share();
        test_overflow();
        test_fill();
        test_reset_mid_fill();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
